// File: rtl/instr_fetch_if.sv
// Instruction fetch bus: memory read port plus decode-side buffer head.
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rvalid,
      input  imem_rdata,
      output instr_valid,
      output instr,
      output instr_pc,
      input  instr_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rvalid,
      output imem_rdata,
      input  instr_valid,
      input  instr,
      input  instr_pc,
      output instr_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// Fetch unit: one outstanding imem read feeding a DEPTH-entry fetch buffer.
// FETCH_ALIGN_CHECK_EN adds sticky fetch_misaligned and blocks misaligned fetches.
module instr_fetch #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic        pc_ack,
   input  logic        flush,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic        fetch_misaligned,
`endif
   instr_fetch_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW+1:0] CAP = (AW+2)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [31:0]   fifo_pc  [DEPTH];
   logic [31:0]   fifo_ins [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW+1:0] occ;
   logic [31:0]   req_pc;
   logic          push;
   logic          pop;
   logic          slot;
   logic          base;
   logic          issue;

   assign push = (state == WAIT) && bus.imem_rvalid && !flush;
   assign pop  = bus.instr_valid && bus.instr_ready;
   assign occ  = {1'b0, count} + (AW+2)'(push) - (AW+2)'(pop);
   assign slot = (state == IDLE) || ((state == WAIT) && bus.imem_rvalid);
   assign base = !rst && !flush && slot && (occ < CAP);

`ifdef FETCH_ALIGN_CHECK_EN
   logic mis_q;

   assign fetch_misaligned = mis_q;
   assign issue = base && !mis_q && (pc[1:0] == 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mis_q <= 1'b0;
      end else if (flush) begin
         mis_q <= 1'b0;
      end else if (base && (pc[1:0] != 2'b00)) begin
         mis_q <= 1'b1;
      end
   end
`else
   assign issue = base;
`endif

   assign bus.imem_req    = issue;
   assign pc_ack          = issue;
   assign bus.imem_addr   = pc & 32'hFFFF_FFFC;
   assign bus.instr_valid = (count != '0);
   assign bus.instr       = fifo_ins[rd_ptr];
   assign bus.instr_pc    = fifo_pc[rd_ptr];

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (issue) state_nxt = WAIT;
         end
         WAIT: begin
            if (flush) begin
               state_nxt = bus.imem_rvalid ? IDLE : DROP;
            end else if (bus.imem_rvalid) begin
               state_nxt = issue ? WAIT : IDLE;
            end
         end
         DROP: begin
            if (bus.imem_rvalid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         req_pc <= '0;
      end else begin
         state <= state_nxt;
         if (issue) req_pc <= pc;
         if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            count <= occ[AW:0];
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

   // Entries are reset too so instr/instr_pc read zero out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_pc[i]  <= '0;
            fifo_ins[i] <= '0;
         end
      end else if (push) begin
         fifo_pc[wr_ptr]  <= req_pc;
         fifo_ins[wr_ptr] <= bus.imem_rdata;
      end
   end
endmodule
